ps2_scan_fifo_rx: RTL and testbench
===================================

# ps2_scan_fifo_rx

Parametrised PS/2 keyboard receiver that turns a raw ps2c/ps2d pair into a queue of decoded key events. It filters the PS/2 clock, checks each frame, decodes the E0 (extended) and F0 (break) prefixes, and buffers {ext, brk, code} events in a first-word-fall-through FIFO. It sits between the keyboard pins and the application logic, and replaces the single-byte receive-and-filter path.

## Interface
- FILTER_LEN, 8: consecutive equal ps2c samples required to change the filtered clock (2..16).
- DEPTH, 8: number of FIFO event entries; power of two, 2..64.
- TIMEOUT_CYC, 50000: clk cycles allowed between filtered falling edges inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ps2d  in  1  PS/2 serial data (asynchronous).
- ps2c  in  1  PS/2 clock (asynchronous).
- EN  in  1  receiver enable.
- rd  in  1  pop request for the FIFO head.
- dato  out  8  head event scan code, without prefixes.
- ext  out  1  head event was E0-prefixed.
- brk  out  1  head event is a break (release); see Configuration.
- valid  out  1  FIFO not empty; dato/ext/brk are meaningful.
- correct  out  1  last completed frame passed parity and stop checks.
- par_err  out  1  one-cycle pulse: frame rejected.
- ovf  out  1  one-cycle pulse: event dropped because the FIFO was full.

## Operation
- ps2c and ps2d each pass through a 2-FF synchroniser. The filtered clock changes only after FILTER_LEN identical synchronised samples. A filtered 1→0 transition is a sample strobe.
- Frame FSM, advanced only on a strobe:
  - IDLE: start bit 0 → DATA; a start bit of 1 is ignored.
  - DATA: shift 8 bits, LSB first → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: check odd parity over data+parity and stop=1 → IDLE. Either check failing makes the frame bad.
- Watchdog: a counter clears on each strobe. If it reaches TIMEOUT_CYC while the FSM is not in IDLE, the FSM returns to IDLE, the partial frame is discarded, and par_err pulses.
- EN=0: the FSM is forced to IDLE, the watchdog is cleared, and any partial frame is discarded. The FIFO stays readable.
- Prefix decoder, on each good frame:
  - E0 sets ext_pend.
  - F0 sets brk_pend.
  - Any other byte emits event {ext_pend, brk_pend, byte}, then clears both pending flags.
  - A bad frame clears both pending flags and sets correct=0. A good frame sets correct=1.
- FIFO: 10-bit entries, DEPTH deep.
  - Push when full: the event is dropped and ovf pulses.
  - rd with valid=0 is ignored.
  - rd while full with a simultaneous push: both happen and no ovf is raised.
- Read and write pointers are log2(DEPTH)+1 bits wide and wrap naturally. Full/empty are decided by pointer MSB comparison.

## Timing
- Reset values: dato=0, ext=0, brk=0, valid=0, correct=0, par_err=0, ovf=0. FSM in IDLE, pending flags and FIFO pointers cleared, filtered clock = 1.
- Filter latency: an edge on ps2c is seen FILTER_LEN+2 cycles after the pin changes.
- The STOP strobe occurs at cycle T:
  - frame result is registered at T+1 (correct and par_err update);
  - push happens at T+2;
  - valid=1 and head outputs update at T+2 if the FIFO was empty.
- Pop: rd=1 at cycle P with valid=1 → the next entry, or valid=0, is shown at P+1.
- ovf and par_err are exactly one cycle wide.
- rst mid-frame takes effect in the same cycle and discards all state.

## Configuration
- PS2_BREAK_EVENTS_EN defined: break events are queued with brk=1.
- PS2_BREAK_EVENTS_EN undefined: F0-prefixed codes are consumed and not queued, brk is tied to 0, and only make events reach the FIFO. This is the legacy filtering behaviour.

## Structure
- Package ps2_pkg holds:
  - constants PS2_EXT_PREFIX=8'hE0 and PS2_BRK_PREFIX=8'hF0;
  - the frame FSM state enum (IDLE, DATA, PARITY, STOP);
  - the 10-bit event type {ext, brk, code}.
- Sub-module ps2_event_fifo, parametrised on DEPTH and width, provides FWFT, full/empty and the ovf pulse.

## Test plan
- Frame 0x1C, good parity, FIFO empty → valid=1 at T+2 with dato=0x1C, ext=0, brk=0, correct=1.
- Sequence E0, F0, 0x75 with the macro defined → one event: dato=0x75, ext=1, brk=1. With the macro undefined → no event and valid stays 0.
- Frame 0x1C with a flipped parity bit → par_err pulses once, correct=0, no event. A following good 0x1B is queued with ext=0.
- Send 3 data bits, then idle for TIMEOUT_CYC cycles → par_err pulse, FSM in IDLE. The next full good frame 0x23 is queued correctly.
- DEPTH=4, send 5 make codes with no rd → 4 queued and ovf pulses on the 5th. Then 4 rd pops return the codes in order and valid drops after the last.
- ps2c glitch shorter than FILTER_LEN cycles, and EN=0 mid-frame → no strobe and no event. After EN=1, a good frame 0x1C is received normally.

Source files
------------

// File: rtl/ps2_scan_fifo_rx_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver (package ps2_pkg).
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

endpackage

// File: rtl/ps2_scan_fifo_rx_event_fifo.sv
// First-word-fall-through event FIFO with MSB-compared wrap pointers and a
// one-cycle overflow pulse when a push is dropped.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_ovf;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_ovf <= i_push && !w_do_push;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/ps2_scan_fifo_rx.sv
// PS/2 keyboard receiver: clock filter, frame FSM, E0/F0 decoder, event FIFO.
// Define PS2_BREAK_EVENTS_EN to queue break events; otherwise F0 codes are dropped.
//
// state  | meaning
// IDLE   | waiting for a start bit (0) on a strobe
// DATA   | shifting 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking stop bit and odd parity, then back to IDLE
module ps2_scan_fifo_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       EN,
  input  logic       rd,
  output logic [7:0] dato,
  output logic       ext,
  output logic       brk,
  output logic       valid,
  output logic       correct,
  output logic       par_err,
  output logic       ovf
);

  localparam int CW = $clog2(FILTER_LEN);
  localparam int WW = $clog2(TIMEOUT_CYC);

  logic          r_c_s1, r_c_s2, r_d_s1, r_d_s2;
  logic          r_c_flt;
  logic [CW-1:0] r_flt_cnt;
  logic [WW-1:0] r_wdog;
  ps2_state_t    r_state, w_state_nx;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitcnt;
  logic          r_par;
  logic          r_res_good, r_correct, r_par_err;
  logic [7:0]    r_res_byte;
  logic          r_ext_pend, r_brk_pend;

  logic          w_flip, w_strobe, w_done, w_abort, w_frame_ok;
  logic          w_is_prefix, w_push, w_empty, w_full;
  ps2_event_t    w_evt, w_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c_s1 <= 1'b1;
      r_c_s2 <= 1'b1;
      r_d_s1 <= 1'b1;
      r_d_s2 <= 1'b1;
    end else begin
      r_c_s1 <= ps2c;
      r_c_s2 <= r_c_s1;
      r_d_s1 <= ps2d;
      r_d_s2 <= r_d_s1;
    end
  end

  // Down-counter of consecutive differing samples; terminal count flips the filter.
  assign w_flip   = (r_c_s2 != r_c_flt) && (r_flt_cnt == '0);
  assign w_strobe = w_flip && r_c_flt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c_flt   <= 1'b1;
      r_flt_cnt <= CW'(FILTER_LEN - 1);
    end else if (r_c_s2 == r_c_flt) begin
      r_flt_cnt <= CW'(FILTER_LEN - 1);
    end else if (w_flip) begin
      r_c_flt   <= r_c_s2;
      r_flt_cnt <= CW'(FILTER_LEN - 1);
    end else begin
      r_flt_cnt <= r_flt_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !EN || w_strobe || r_state == IDLE) r_wdog <= WW'(TIMEOUT_CYC - 1);
    else if (r_wdog != '0)                           r_wdog <= r_wdog - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_done     = 1'b0;
    w_abort    = 1'b0;
    if (!EN) begin
      w_state_nx = IDLE;
    end else if (w_strobe) begin
      case (r_state)
        IDLE:    if (!r_d_s2) w_state_nx = DATA;
        DATA:    if (r_bitcnt == 3'd7) w_state_nx = PARITY;
        PARITY:  w_state_nx = STOP;
        STOP: begin
          w_state_nx = IDLE;
          w_done     = 1'b1;
        end
        default: w_state_nx = IDLE;
      endcase
    end else if (r_state != IDLE && r_wdog == '0) begin
      w_state_nx = IDLE;
      w_abort    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_par    <= 1'b0;
    end else if (EN && w_strobe) begin
      case (r_state)
        IDLE:   r_bitcnt <= '0;
        DATA: begin
          r_shift  <= {r_d_s2, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 3'd1;
        end
        PARITY: r_par <= r_d_s2;
        default: ;
      endcase
    end
  end

  assign w_frame_ok = r_d_s2 && (^{r_shift, r_par});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_good <= 1'b0;
      r_res_byte <= '0;
      r_correct  <= 1'b0;
      r_par_err  <= 1'b0;
    end else begin
      r_res_good <= w_done && w_frame_ok;
      r_par_err  <= (w_done && !w_frame_ok) || w_abort;
      if (w_done) begin
        r_res_byte <= r_shift;
        r_correct  <= w_frame_ok;
      end else if (w_abort) begin
        r_correct  <= 1'b0;
      end
    end
  end

  assign w_is_prefix = (r_res_byte == PS2_EXT_PREFIX) || (r_res_byte == PS2_BRK_PREFIX);

  always_comb begin
    w_evt.ext  = r_ext_pend;
    w_evt.code = r_res_byte;
    w_push     = 1'b0;
`ifdef PS2_BREAK_EVENTS_EN
    w_evt.brk  = r_brk_pend;
    if (r_res_good && !w_is_prefix) w_push = 1'b1;
`else
    w_evt.brk  = 1'b0;
    if (r_res_good && !w_is_prefix) w_push = !r_brk_pend;
`endif
  end

  // A rejected frame breaks any prefix chain in progress.
  always_ff @(posedge clk) begin
    if (rst || r_par_err) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (r_res_good) begin
      if (r_res_byte == PS2_EXT_PREFIX) begin
        r_ext_pend <= 1'b1;
      end else if (r_res_byte == PS2_BRK_PREFIX) begin
        r_brk_pend <= 1'b1;
      end else begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(ps2_event_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_evt),
    .i_pop   (rd),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_ovf   (ovf)
  );

  assign dato    = w_head.code;
  assign ext     = w_head.ext;
  // Without break events the FIFO brk bit is only ever written 0.
  assign brk     = w_head.brk;
  assign valid   = !w_empty;
  assign correct = r_correct;
  assign par_err = r_par_err;

endmodule

// File: tb/tb_ps2_scan_fifo_rx.sv
// Bench for ps2_scan_fifo_rx: event-level queue model checked every cycle,
// directed scenarios with literal expectations, then randomized frames and pops.
module tb_ps2_scan_fifo_rx;

  localparam int F     = 8;
  localparam int DEPTH = 4;
  localparam int TO    = 300;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2d = 1'b1;
  logic       ps2c = 1'b1;
  logic       EN = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] dato;
  logic       ext, brk, valid, correct, par_err, ovf;

  ps2_scan_fifo_rx #(.FILTER_LEN(F), .DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ps2d(ps2d), .ps2c(ps2c), .EN(EN), .rd(rd),
    .dato(dato), .ext(ext), .brk(brk), .valid(valid),
    .correct(correct), .par_err(par_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_par    = 0;
  int n_ovf    = 0;
  bit chk_en   = 0;

  // Model: frame result scheduled at the edge the DUT registers it.
  int         res_edge  = -1;
  bit         res_good  = 0;
  logic [7:0] res_byte  = '0;
  int         push_edge = -1;
  logic [9:0] push_evt  = '0;
  logic [9:0] mq[$];
  bit         m_ext_p = 0, m_brk_p = 0;
  bit         m_correct = 0, m_par = 0, m_ovf = 0;

  always @(posedge clk) begin
    bit do_pop;
    cyc = cyc + 1;
    if (rst) begin
      mq.delete();
      m_ext_p = 0; m_brk_p = 0; m_correct = 0; m_par = 0; m_ovf = 0;
      push_edge = -1;
    end else begin
      m_par = 0;
      m_ovf = 0;
      do_pop = rd && (mq.size() != 0);
      if (push_edge == cyc) begin
        if (mq.size() == DEPTH && !do_pop) m_ovf = 1;
        else begin
          if (do_pop) begin void'(mq.pop_front()); do_pop = 0; end
          mq.push_back(push_evt);
        end
      end
      if (do_pop) void'(mq.pop_front());
      if (res_edge == cyc) begin
        if (res_good) begin
          m_correct = 1;
          if (res_byte == 8'hE0) m_ext_p = 1;
          else if (res_byte == 8'hF0) m_brk_p = 1;
          else begin
`ifdef PS2_BREAK_EVENTS_EN
            push_evt = {m_ext_p, m_brk_p, res_byte}; push_edge = cyc + 1;
`else
            if (!m_brk_p) begin push_evt = {m_ext_p, 1'b0, res_byte}; push_edge = cyc + 1; end
`endif
            m_ext_p = 0; m_brk_p = 0;
          end
        end else begin
          m_correct = 0; m_par = 1; m_ext_p = 0; m_brk_p = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit ok;
    logic [9:0] eh;
    if (par_err) n_par++;
    if (ovf) n_ovf++;
    if (chk_en) begin
      n_checks++;
      eh = (mq.size() != 0) ? mq[0] : 10'h0;
      ok = (valid === (mq.size() != 0)) && (correct === m_correct) &&
           (par_err === m_par) && (ovf === m_ovf);
      if (ok && mq.size() != 0) ok = ({ext, brk, dato} === eh);
      if (!ok) begin
        n_err++;
        $display("FAIL model_cmp cyc=%0d got v=%b e=%b b=%b d=%h c=%b pe=%b o=%b exp v=%b head=%h c=%b pe=%b o=%b",
                 cyc, valid, ext, brk, dato, correct, par_err, ovf,
                 mq.size() != 0, eh, m_correct, m_par, m_ovf);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n, output int k);
    k = 0;
    for (int i = 0; i < n; i++) begin
      ps2d = bits[i];
      tick(HALF);
      ps2c = 1'b0;
      k = cyc;
      if (i != n - 1) begin tick(HALF); ps2c = 1'b1; end
    end
  endtask

  task automatic release_clk();
    tick(HALF);
    ps2c = 1'b1;
    ps2d = 1'b1;
    tick(HALF);
  endtask

  // Leaves ps2c low after the stop bit so the caller can probe timing.
  task automatic send_frame(input logic [7:0] b, input bit bad, output int k);
    logic par, stp;
    par = ~(^b);
    stp = 1'b1;
    if (bad) begin
      if ($urandom_range(0, 1) == 0) par = ~par;
      else stp = 1'b0;
    end
    send_bits({stp, par, b, 1'b0}, 11, k);
    res_byte = b;
    res_good = !bad;
    res_edge = k + F + 2;
  endtask

  task automatic send_full(input logic [7:0] b, input bit bad);
    int k;
    send_frame(b, bad, k);
    release_clk();
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && valid; i++) begin rd = 1'b1; tick(1); rd = 1'b0; end
    check("drain_empty", valid, 0);
  endtask

  initial begin
    int k, p0, o0;
    logic [7:0] codes [5];
    bit done;
    codes[0] = 8'h16; codes[1] = 8'h1E; codes[2] = 8'h26; codes[3] = 8'h25; codes[4] = 8'h2E;

    tick(4);
    check("rst_valid", valid, 0);
    check("rst_dato", dato, 0);
    check("rst_flags", {ext, brk, correct, par_err, ovf}, 0);
    rst = 1'b0;
    tick(1);
    chk_en = 1;
    tick(5);

    // 0x1C: result at T+1, event at T+2
    send_frame(8'h1C, 0, k);
    while (cyc < k + F + 1) tick(1);
    check("t1_correct_before", correct, 0);
    tick(1);
    check("t1_correct_T1", correct, 1);
    check("t1_valid_T1", valid, 0);
    tick(1);
    check("t1_valid_T2", valid, 1);
    check("t1_head", {ext, brk, dato}, {2'b00, 8'h1C});
    release_clk();
    drain();

    send_full(8'hE0, 0);
    send_full(8'hF0, 0);
    send_full(8'h75, 0);
    tick(5);
`ifdef PS2_BREAK_EVENTS_EN
    check("e0f0_valid", valid, 1);
    check("e0f0_head", {ext, brk, dato}, {2'b11, 8'h75});
`else
    check("e0f0_valid", valid, 0);
`endif
    drain();

    p0 = n_par;
    send_full(8'h1C, 1);
    tick(5);
    check("bad_par_pulses", n_par - p0, 1);
    check("bad_correct", correct, 0);
    check("bad_valid", valid, 0);
    send_full(8'h1B, 0);
    tick(5);
    check("after_bad_head", {valid, ext, brk, dato}, {3'b100, 8'h1B});
    drain();

    // partial frame: start + 3 data bits, then silence
    p0 = n_par;
    send_bits(11'b000_0000_1010, 4, k);
    release_clk();
    res_byte = 8'h00; res_good = 0; res_edge = k + F + 2 + TO;
    tick(TO + 20);
    check("timeout_pulses", n_par - p0, 1);
    send_full(8'h23, 0);
    tick(5);
    check("timeout_next_head", {valid, ext, brk, dato}, {3'b100, 8'h23});
    drain();

    o0 = n_ovf;
    for (int i = 0; i < 5; i++) send_full(codes[i], 0);
    tick(5);
    check("ovf_pulses", n_ovf - o0, 1);
    for (int i = 0; i < 4; i++) begin
      check("ovf_pop_order", {valid, dato}, {1'b1, codes[i]});
      rd = 1'b1; tick(1); rd = 1'b0;
    end
    check("ovf_valid_drop", valid, 0);

    // glitch shorter than the filter with data low, then EN=0 mid-frame
    p0 = n_par;
    ps2d = 1'b0;
    tick(3);
    ps2c = 1'b0; tick(F - 3); ps2c = 1'b1;
    tick(HALF);
    ps2d = 1'b1;
    send_bits(11'b000_0000_0110, 3, k);
    release_clk();
    EN = 1'b0;
    send_bits(11'b000_0000_0010, 2, k);
    release_clk();
    tick(TO + 20);
    EN = 1'b1;
    tick(5);
    check("en_no_event", valid, 0);
    send_full(8'h1C, 0);
    tick(5);
    check("en_head", {valid, ext, brk, dato}, {3'b100, 8'h1C});
    check("en_no_par", n_par - p0, 0);
    drain();

    done = 0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          logic [7:0] b;
          case ($urandom_range(0, 5))
            0: b = 8'hE0;
            1: b = 8'hF0;
            default: b = 8'($urandom_range(0, 255));
          endcase
          send_full(b, $urandom_range(0, 7) == 0);
        end
        tick(5);
        done = 1;
      end
      begin
        while (!done) begin
          rd = ($urandom_range(0, 9) == 0);
          tick(1);
        end
        rd = 1'b0;
      end
    join

    tick(5);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
